// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared phase encoding, default address map and index-width helper for the GCN memory server
package gcn_pkg;

    typedef enum logic [1:0] {
        LOAD_WM,
        LOAD_FM,
        LOAD_COO,
        SERVE
    } phase_e;

    localparam int WEIGHT_COLS     = 3;
    localparam int FEATURE_ROWS    = 6;
    localparam int COO_NUM_OF_COLS = 6;
    localparam int FEATURE_BASE    = 512;

    // Index width for a table of 'depth' entries; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/gcn_vector_bank.sv
// rtl/gcn_vector_bank.sv - depth x vector register file, one write port and one registered read port
module gcn_vector_bank
    import gcn_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int ROWS  = 96,
    parameter int WIDTH = 5,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,                  // single clock domain
    input  logic             wr_en,                // write wr_data into entry wr_index
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WIDTH-1:0] wr_data [0:ROWS-1],
    input  logic             rd_en,                // capture entry rd_index into rd_data
    input  logic [IDX_W-1:0] rd_index,
    output logic [WIDTH-1:0] rd_data [0:ROWS-1]    // registered; holds while rd_en is low
);

    // Storage is deliberately not reset: contents are undefined until loaded.
    logic [WIDTH-1:0] mem       [0:DEPTH-1][0:ROWS-1];
    logic [WIDTH-1:0] rd_data_d [0:ROWS-1];
    logic [WIDTH-1:0] rd_data_q [0:ROWS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[wr_index][i] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            rd_data_d[i] = rd_en ? mem[rd_index][i] : rd_data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            rd_data_q[i] <= rd_data_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            rd_data[i] = rd_data_q[i];
        end
    end

endmodule

// File: rtl/gcn_memory_server.sv
// rtl/gcn_memory_server.sv - loadable weight/feature/COO store serving accelerator reads with one-cycle latency
module gcn_memory_server #(
    parameter int WEIGHT_ROWS     = 96,
    parameter int WEIGHT_COLS     = gcn_pkg::WEIGHT_COLS,
    parameter int FEATURE_ROWS    = gcn_pkg::FEATURE_ROWS,
    parameter int WEIGHT_WIDTH    = 5,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int FEATURE_BASE    = gcn_pkg::FEATURE_BASE,
    parameter int COO_NUM_OF_COLS = gcn_pkg::COO_NUM_OF_COLS,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input  logic                     clk,                           // single clock domain
    input  logic                     reset,                         // synchronous, active high
    input  logic                     load_valid,                    // load beat present
    output logic                     load_ready,                    // high in every LOAD_* phase
    input  logic [WEIGHT_WIDTH-1:0]  load_data [0:WEIGHT_ROWS-1],   // weight column / feature row beat
    input  logic [COO_BW-1:0]        load_coo [0:1],                // (src, dst) edge beat
    input  logic                     reload,                        // restart loading from SERVE
    output logic                     loaded,                        // high while serving
    input  logic                     enable_read,                   // read request
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [COO_BW-1:0]        coo_address,                   // edge index
    output logic [WEIGHT_WIDTH-1:0]  data_out [0:WEIGHT_ROWS-1],    // read data, one cycle after request
    output logic                     data_valid,                    // single-cycle pulse per valid read
    output logic                     addr_error,                    // single-cycle pulse per out-of-range read
    output logic [COO_BW-1:0]        coo_out [0:1]                  // edge at previous coo_address
);

    localparam int W_IDX_W = gcn_pkg::idx_width(WEIGHT_COLS);
    localparam int F_IDX_W = gcn_pkg::idx_width(FEATURE_ROWS);

    // Which bank data_out is currently showing; ZERO forces the bus low.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_W,
        SRC_F
    } src_e;

    gcn_pkg::phase_e phase_q, phase_d;
    logic [3:0]      beat_q, beat_d;
    src_e            src_q, src_d;
    logic            data_valid_q, data_valid_d;
    logic            addr_error_q, addr_error_d;
    logic [COO_BW-1:0] coo_src_q, coo_src_d;
    logic [COO_BW-1:0] coo_dst_q, coo_dst_d;

    logic serve;
    logic beat_acc;
    logic in_w;
    logic in_f;
    logic w_wr_en;
    logic f_wr_en;
    logic coo_wr_en;
    logic w_rd_en;
    logic f_rd_en;
    logic [W_IDX_W-1:0] w_wr_index;
    logic [F_IDX_W-1:0] f_wr_index;
    logic [COO_BW-1:0]  coo_wr_index;
    logic [W_IDX_W-1:0] w_rd_index;
    logic [F_IDX_W-1:0] f_rd_index;

    logic [WEIGHT_WIDTH-1:0] w_rd_data [0:WEIGHT_ROWS-1];
    logic [WEIGHT_WIDTH-1:0] f_rd_data [0:WEIGHT_ROWS-1];

    logic [COO_BW-1:0] coo_src_mem [0:COO_NUM_OF_COLS-1];
    logic [COO_BW-1:0] coo_dst_mem [0:COO_NUM_OF_COLS-1];

    assign serve      = (phase_q == gcn_pkg::SERVE);
    assign loaded     = serve;
    assign load_ready = !serve;
    assign beat_acc   = load_valid && load_ready;

    // The beat counter doubles as the write index of whichever table is loading.
    assign w_wr_index   = beat_q[W_IDX_W-1:0];
    assign f_wr_index   = beat_q[F_IDX_W-1:0];
    assign coo_wr_index = beat_q[COO_BW-1:0];

    always_comb begin
        phase_d   = phase_q;
        beat_d    = beat_q;
        w_wr_en   = 1'b0;
        f_wr_en   = 1'b0;
        coo_wr_en = 1'b0;
        unique case (phase_q)
            gcn_pkg::LOAD_WM: begin
                if (beat_acc) begin
                    w_wr_en = 1'b1;
                    if (beat_q == 4'(WEIGHT_COLS - 1)) begin
                        phase_d = gcn_pkg::LOAD_FM;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            gcn_pkg::LOAD_FM: begin
                if (beat_acc) begin
                    f_wr_en = 1'b1;
                    if (beat_q == 4'(FEATURE_ROWS - 1)) begin
                        phase_d = gcn_pkg::LOAD_COO;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            gcn_pkg::LOAD_COO: begin
                if (beat_acc) begin
                    coo_wr_en = 1'b1;
                    if (beat_q == 4'(COO_NUM_OF_COLS - 1)) begin
                        phase_d = gcn_pkg::SERVE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            gcn_pkg::SERVE: begin
                if (reload) begin
                    phase_d = gcn_pkg::LOAD_WM;
                    beat_d  = '0;
                end
            end
            default: begin
                phase_d = gcn_pkg::LOAD_WM;
                beat_d  = '0;
            end
        endcase
    end

    // Address map: weight columns at the bottom, feature rows from FEATURE_BASE up.
    assign in_w       = int'(read_address) < WEIGHT_COLS;
    assign in_f       = (int'(read_address) >= FEATURE_BASE) &&
                        (int'(read_address) < FEATURE_BASE + FEATURE_ROWS);
    assign w_rd_index = W_IDX_W'(read_address);
    assign f_rd_index = F_IDX_W'(read_address - ADDRESS_WIDTH'(FEATURE_BASE));
    assign w_rd_en    = serve && enable_read && in_w;
    assign f_rd_en    = serve && enable_read && in_f;

    always_comb begin
        src_d        = src_q;
        data_valid_d = 1'b0;
        addr_error_d = 1'b0;
        coo_src_d    = '0;
        coo_dst_d    = '0;
        if (!serve) begin
            src_d = SRC_ZERO;
        end else begin
            // Without a request src holds, so data_out keeps showing the last read.
            if (enable_read) begin
                if (in_w) begin
                    src_d        = SRC_W;
                    data_valid_d = 1'b1;
                end else if (in_f) begin
                    src_d        = SRC_F;
                    data_valid_d = 1'b1;
                end else begin
                    src_d        = SRC_ZERO;
                    addr_error_d = 1'b1;
                end
            end
            if (int'(coo_address) < COO_NUM_OF_COLS) begin
                coo_src_d = coo_src_mem[coo_address];
                coo_dst_d = coo_dst_mem[coo_address];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (coo_wr_en) begin
            coo_src_mem[coo_wr_index] <= load_coo[0];
            coo_dst_mem[coo_wr_index] <= load_coo[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= gcn_pkg::LOAD_WM;
            beat_q       <= '0;
            src_q        <= SRC_ZERO;
            data_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            coo_src_q    <= '0;
            coo_dst_q    <= '0;
        end else begin
            phase_q      <= phase_d;
            beat_q       <= beat_d;
            src_q        <= src_d;
            data_valid_q <= data_valid_d;
            addr_error_q <= addr_error_d;
            coo_src_q    <= coo_src_d;
            coo_dst_q    <= coo_dst_d;
        end
    end

    gcn_vector_bank #(
        .DEPTH (WEIGHT_COLS),
        .ROWS  (WEIGHT_ROWS),
        .WIDTH (WEIGHT_WIDTH)
    ) u_weight_bank (
        .clk      (clk),
        .wr_en    (w_wr_en),
        .wr_index (w_wr_index),
        .wr_data  (load_data),
        .rd_en    (w_rd_en),
        .rd_index (w_rd_index),
        .rd_data  (w_rd_data)
    );

    gcn_vector_bank #(
        .DEPTH (FEATURE_ROWS),
        .ROWS  (WEIGHT_ROWS),
        .WIDTH (WEIGHT_WIDTH)
    ) u_feature_bank (
        .clk      (clk),
        .wr_en    (f_wr_en),
        .wr_index (f_wr_index),
        .wr_data  (load_data),
        .rd_en    (f_rd_en),
        .rd_index (f_rd_index),
        .rd_data  (f_rd_data)
    );

    always_comb begin
        for (int i = 0; i < WEIGHT_ROWS; i++) begin
            data_out[i] = '0;
            if (src_q == SRC_W) begin
                data_out[i] = w_rd_data[i];
            end else if (src_q == SRC_F) begin
                data_out[i] = f_rd_data[i];
            end
        end
    end

    assign data_valid = data_valid_q;
    assign addr_error = addr_error_q;

    always_comb begin
        coo_out[0] = coo_src_q;
        coo_out[1] = coo_dst_q;
    end

endmodule

// File: tb/tb_gcn_memory_server.sv
// tb/tb_gcn_memory_server.sv - scoreboard bench for gcn_memory_server
module tb_gcn_memory_server;

    localparam int WR = 96;
    localparam int WW = 5;
    localparam int AW = 13;
    localparam int CB = 3;
    localparam int VW = WR * WW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [WW-1:0] load_data [0:WR-1];
    logic [CB-1:0] load_coo [0:1];
    logic          reload = 1'b0;
    logic          loaded;
    logic          enable_read = 1'b0;
    logic [AW-1:0] read_address = '0;
    logic [CB-1:0] coo_address = '0;
    logic [WW-1:0] data_out [0:WR-1];
    logic          data_valid;
    logic          addr_error;
    logic [CB-1:0] coo_out [0:1];

    logic [VW-1:0] dout_flat;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int w_v [3];
    int f_v [6];
    int c_s [6];
    int c_d [6];

    typedef struct {
        int            due;
        string         name;
        bit            chk_rd;
        bit            exp_valid;
        bit            exp_err;
        logic [VW-1:0] exp_data;
        bit            chk_coo;
        logic [CB-1:0] exp_src;
        logic [CB-1:0] exp_dst;
        bit            chk_st;
        bit            exp_ready;
        bit            exp_loaded;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    gcn_memory_server dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_coo     (load_coo),
        .reload       (reload),
        .loaded       (loaded),
        .enable_read  (enable_read),
        .read_address (read_address),
        .coo_address  (coo_address),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .addr_error   (addr_error),
        .coo_out      (coo_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < WR; i++) begin
            dout_flat[i*WW +: WW] = data_out[i];
        end
    end

    function automatic logic [VW-1:0] all_val(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < WR; i++) r[i*WW +: WW] = WW'(v);
        return r;
    endfunction

    function automatic exp_t blank(input string nm, input int due);
        exp_t e;
        e.due = due; e.name = nm;
        e.chk_rd = 0; e.exp_valid = 0; e.exp_err = 0; e.exp_data = '0;
        e.chk_coo = 0; e.exp_src = '0; e.exp_dst = '0;
        e.chk_st = 0; e.exp_ready = 0; e.exp_loaded = 0;
        return e;
    endfunction

    task automatic exp_rd(input string nm, input int due, input bit v, input bit er, input logic [VW-1:0] d);
        exp_t e;
        e = blank(nm, due);
        e.chk_rd = 1; e.exp_valid = v; e.exp_err = er; e.exp_data = d;
        sb.push_back(e);
    endtask

    task automatic exp_coo(input string nm, input int due, input int s, input int d);
        exp_t e;
        e = blank(nm, due);
        e.chk_coo = 1; e.exp_src = CB'(s); e.exp_dst = CB'(d);
        sb.push_back(e);
    endtask

    task automatic exp_st(input string nm, input int due, input bit rdy, input bit ld);
        exp_t e;
        e = blank(nm, due);
        e.chk_st = 1; e.exp_ready = rdy; e.exp_loaded = ld;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares every expectation that falls due this cycle; also flags pulses nobody asked for.
    always @(negedge clk) begin
        bit rd_checked;
        exp_t e;
        rd_checked = 0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.name, e.due, cyc);
            end else begin
                if (e.chk_rd) begin
                    rd_checked = 1;
                    check({e.name, "_valid"}, VW'(data_valid), VW'(e.exp_valid));
                    check({e.name, "_err"}, VW'(addr_error), VW'(e.exp_err));
                    check({e.name, "_data"}, dout_flat, e.exp_data);
                end
                if (e.chk_coo) begin
                    check({e.name, "_src"}, VW'(coo_out[0]), VW'(e.exp_src));
                    check({e.name, "_dst"}, VW'(coo_out[1]), VW'(e.exp_dst));
                end
                if (e.chk_st) begin
                    check({e.name, "_ready"}, VW'(load_ready), VW'(e.exp_ready));
                    check({e.name, "_loaded"}, VW'(loaded), VW'(e.exp_loaded));
                end
            end
        end
        if (!rd_checked && (data_valid === 1'b1 || addr_error === 1'b1)) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_pulse at cycle %0d: data_valid=%0b addr_error=%0b, expected 0/0", cyc, data_valid, addr_error);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int v);
        for (int i = 0; i < WR; i++) load_data[i] = WW'(v);
    endtask

    task automatic beat_vec(input int v);
        load_valid = 1'b1;
        set_vec(v);
        step();
    endtask

    task automatic load_all(input bit with_gap, input bit pulse_reload);
        for (int k = 0; k < 3; k++) beat_vec(w_v[k]);
        for (int k = 0; k < 6; k++) begin
            if (with_gap && k == 2) begin
                load_valid = 1'b0;
                enable_read = 1'b1;
                read_address = '0;
                exp_st("gap_status", cyc, 1'b1, 1'b0);
                exp_rd("read_in_load_fm", cyc + 1, 1'b0, 1'b0, '0);
                step();
                enable_read = 1'b0;
                step();
            end
            reload = pulse_reload && (k == 0);
            beat_vec(f_v[k]);
            reload = 1'b0;
        end
        for (int k = 0; k < 6; k++) begin
            load_valid = 1'b1;
            set_vec(31);
            load_coo[0] = CB'(c_s[k]);
            load_coo[1] = CB'(c_d[k]);
            if (k == 5) begin
                exp_st("last_beat_status", cyc, 1'b1, 1'b0);
                exp_st("loaded_rise", cyc + 1, 1'b0, 1'b1);
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic do_read(input string nm, input int addr, input bit ok, input int v);
        enable_read = 1'b1;
        read_address = AW'(addr);
        exp_rd(nm, cyc + 1, ok, !ok, ok ? all_val(v) : '0);
        step();
        enable_read = 1'b0;
    endtask

    task automatic do_coo(input string nm, input int addr, input int s, input int d);
        coo_address = CB'(addr);
        exp_coo(nm, cyc + 1, s, d);
        step();
    endtask

    int ok_addr [6] = '{1, 515, 0, 2, 512, 517};
    int ok_val  [6] = '{2, 7, 1, 3, 4, 9};
    int bad_addr [4] = '{3, 511, 518, 8191};

    initial begin
        set_vec(0);
        load_coo[0] = '0;
        load_coo[1] = '0;
        step();
        step();
        reset = 1'b0;
        exp_rd("reset_rd", cyc, 1'b0, 1'b0, '0);
        exp_coo("reset_coo", cyc, 0, 0);
        exp_st("reset_status", cyc, 1'b1, 1'b0);

        w_v = '{1, 2, 3};
        f_v = '{4, 5, 6, 7, 8, 9};
        c_s = '{0, 1, 2, 3, 4, 5};
        c_d = '{1, 2, 3, 4, 5, 0};
        load_all(1'b1, 1'b0);

        for (int i = 0; i < 6; i++) do_read("read_ok", ok_addr[i], 1'b1, ok_val[i]);
        exp_rd("hold_no_request", cyc + 1, 1'b0, 1'b0, all_val(9));
        step();
        for (int i = 0; i < 4; i++) do_read("read_bad", bad_addr[i], 1'b0, 0);
        for (int i = 0; i < 6; i++) do_coo("coo_edge", i, i, (i + 1) % 6);
        do_coo("coo_out_of_range7", 7, 0, 0);
        do_coo("coo_out_of_range6", 6, 0, 0);

        enable_read = 1'b1;
        read_address = AW'(2);
        reload = 1'b1;
        exp_rd("reload_read", cyc + 1, 1'b1, 1'b0, all_val(3));
        exp_st("reload_status", cyc + 1, 1'b1, 1'b0);
        step();
        reload = 1'b0;
        enable_read = 1'b0;
        exp_rd("load_wm_zero_out", cyc + 1, 1'b0, 1'b0, '0);
        step();

        for (int k = 0; k < 3; k++) beat_vec(10 + k);
        for (int k = 0; k < 2; k++) beat_vec(13 + k);
        load_valid = 1'b0;
        reset = 1'b1;
        exp_st("reset_mid_load", cyc + 1, 1'b1, 1'b0);
        step();
        reset = 1'b0;

        w_v = '{10, 11, 12};
        f_v = '{20, 21, 22, 23, 24, 25};
        c_s = '{5, 4, 3, 2, 1, 0};
        c_d = '{0, 1, 2, 3, 4, 5};
        load_all(1'b0, 1'b1);

        do_read("reload_w0", 0, 1'b1, 10);
        do_read("reload_w1", 1, 1'b1, 11);
        do_read("reload_w2", 2, 1'b1, 12);
        do_read("reload_f0", 512, 1'b1, 20);
        do_read("reload_f5", 517, 1'b1, 25);
        do_read("reload_f2", 514, 1'b1, 22);
        do_coo("reload_coo0", 0, 5, 0);
        do_coo("reload_coo3", 3, 2, 3);
        do_coo("reload_coo5", 5, 0, 5);
        do_coo("reload_coo6", 6, 0, 0);

        reset = 1'b1;
        exp_st("reset_mid_serve", cyc + 1, 1'b1, 1'b0);
        exp_rd("reset_mid_serve_rd", cyc + 1, 1'b0, 1'b0, '0);
        step();
        reset = 1'b0;

        step();
        step();
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gcn_memory_server.md
# gcn_memory_server

- Memory responder on the far side of the GCN accelerator's read interface.
- A host-side load port fills it with:
  - the weight matrix (WEIGHT_COLS column vectors);
  - the feature matrix (FEATURE_ROWS row vectors);
  - the 2×COO_NUM_OF_COLS COO edge list.
- Once loaded, it serves the accelerator's `enable_read`/`read_address` and `coo_address` requests with one-cycle registered latency, driving the accelerator's `data_in` and `coo_in` buses.
- Used as the testbench/SoC-side storage model and as the synthesizable on-chip buffer.

## Interface

Parameters:
- WEIGHT_ROWS, 96, elements per vector (weight column / feature row)
- WEIGHT_COLS, 3, number of weight columns
- FEATURE_ROWS, 6, number of feature rows
- WEIGHT_WIDTH, 5, bits per element
- ADDRESS_WIDTH, 13, read address width
- FEATURE_BASE, 512, address of feature row 0
- COO_NUM_OF_COLS, 6, number of edges
- COO_BW, $clog2(COO_NUM_OF_COLS), node index width

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load beat present
- load_ready  out  1  block accepts load beats
- load_data  in  WEIGHT_WIDTH × [0:WEIGHT_ROWS-1]  vector for weight/feature beats
- load_coo  in  COO_BW × [0:1]  edge (src, dst) for COO beats
- reload  in  1  single-cycle request to restart loading
- loaded  out  1  high while in SERVE
- enable_read  in  1  read request
- read_address  in  ADDRESS_WIDTH  read address
- coo_address  in  COO_BW  edge index
- data_out  out  WEIGHT_WIDTH × [0:WEIGHT_ROWS-1]  read data; connects to accelerator `data_in`
- data_valid  out  1  data_out valid this cycle
- addr_error  out  1  previous request decoded out of range
- coo_out  out  COO_BW × [0:1]  edge at coo_address; connects to accelerator `coo_in`

## Operation

Phases:
- States: LOAD_WM → LOAD_FM → LOAD_COO → SERVE.
- A beat is accepted when load_valid && load_ready.
- `load_ready` = 1 in all LOAD_* states, 0 in SERVE.

Beat counter (4 bits, cleared on every phase entry):
- LOAD_WM: beat k writes weight column k. After beat WEIGHT_COLS-1 → LOAD_FM.
- LOAD_FM: beat k writes feature row k. After beat FEATURE_ROWS-1 → LOAD_COO.
- LOAD_COO: beat k writes COO edge k from load_coo; load_data is ignored. After beat COO_NUM_OF_COLS-1 → SERVE.
- In weight/feature phases, load_coo is ignored.

Reload:
- `reload` in SERVE → LOAD_WM with counter cleared.
- `reload` in a LOAD state is ignored.

Read decode (evaluated in SERVE only):
- read_address < WEIGHT_COLS → weight column[read_address].
- FEATURE_BASE ≤ read_address < FEATURE_BASE+FEATURE_ROWS → feature row[read_address-FEATURE_BASE].
- Anything else → out of range: data_out = 0, data_valid = 0, addr_error = 1.

COO read:
- coo_out = {src[coo_address], dst[coo_address]}.
- coo_address ≥ COO_NUM_OF_COLS → coo_out = 0.

Outside SERVE:
- Reads are ignored: data_valid = 0, addr_error = 0, data_out = 0, coo_out = 0.

Storage:
- Not cleared by reset; contents are undefined until written.

## Timing

Reset values:
- load_ready = 1, loaded = 0, data_valid = 0, addr_error = 0, data_out = 0, coo_out = 0.
- State = LOAD_WM, beat counter = 0.

Reset mid-load or mid-serve:
- Next cycle is LOAD_WM with counter 0 and loaded = 0.
- Partially written contents remain but are overwritten by the next load.

Phase/status timing:
- Final COO beat accepted in cycle N → loaded = 1 and load_ready = 0 in cycle N+1.
- A read presented in cycle N+1 is served.

Read latency (exactly 1 cycle, fully registered):
- Request in cycle N → data_out, data_valid, addr_error in cycle N+1.
- coo_address in cycle N → coo_out in cycle N+1.

Throughput and hold:
- Back-to-back reads are supported every cycle; no stall.
- With no request, data_out holds its last value; data_valid and addr_error are single-cycle pulses.

Simultaneous events:
- reload and enable_read in the same SERVE cycle: the read is served from the current contents (response in N+1); the state enters LOAD_WM in N+1.
- Load beats are never blocked except in SERVE.

## Structure

Shared package gcn_pkg holds:
- Phase enum {LOAD_WM, LOAD_FM, LOAD_COO, SERVE}.
- Constants FEATURE_BASE, WEIGHT_COLS, FEATURE_ROWS, COO_NUM_OF_COLS.

Sub-module gcn_vector_bank:
- Parameterized depth × vector register file.
- One write port (index, enable, vector) and one registered read port.
- Instantiated twice: weight bank and feature bank.
- The COO edge list is a small local register array.

## Test plan

- Load W columns = {all 1s, all 2s, all 3s}, F rows r = all (r+4), COO src = {0,1,2,3,4,5}, dst = {1,2,3,4,5,0} → loaded rises the cycle after the 15th beat; read 1 → next cycle data_out all 2s, data_valid = 1; read 515 → all 7s.
- Reads at 3, 511 and 518 in SERVE → addr_error = 1, data_valid = 0, data_out = 0 one cycle later.
- coo_address 0..5 on consecutive cycles → coo_out (0,1),(1,2),…,(5,0) each one cycle later; coo_address 7 → (0,0).
- Read 0 during LOAD_FM → data_valid = 0, addr_error = 0; load_valid held low mid-phase → counter holds, phase completes on resumption.
- reset asserted after 5 beats → load_ready = 1, loaded = 0 next cycle; full reload then serves the new values.
- reload with read 2 in the same cycle → all-3s response next cycle, load_ready = 1 and loaded = 0 next cycle.
